tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_pkg.sv | 26 ++
 rtl/tmds_sym_decode.sv | 43 ++++
 rtl/tmds_decoder.sv | 165 ++++++++++++++++
 tb/tb_tmds_decoder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the TMDS encoder/decoder pair:
//   - the four 10-bit control symbols (bit 0 is the first bit on the wire)
//   - the decoder alignment FSM state type
//   - a helper that advances the bit-slip offset with wrap 9 -> 0
// -----------------------------------------------------------------------------
package tmds_pkg;

    localparam logic [9:0] CTL_SYM_00 = 10'b1101010100;
    localparam logic [9:0] CTL_SYM_01 = 10'b0010101011;
    localparam logic [9:0] CTL_SYM_10 = 10'b0101010100;
    localparam logic [9:0] CTL_SYM_11 = 10'b1010101011;

    localparam logic [3:0] OFFSET_LAST = 4'd9;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } tmds_state_e;

    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off >= OFFSET_LAST) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_sym_decode.sv
// -----------------------------------------------------------------------------
// tmds_sym_decode
// Purely combinational 10b -> 8b / control decode of one aligned TMDS symbol.
// Ports:
//   sym    in  10  aligned symbol, bit 0 first on the wire
//   is_ctl out 1   symbol is one of the four control symbols
//   ctl    out 2   decoded control bits {c1,c0} (0 when not a control symbol)
//   d      out 8   decoded data byte (meaningful only when is_ctl = 0)
// -----------------------------------------------------------------------------
module tmds_sym_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctl,
    output logic [1:0] ctl,
    output logic [7:0] d
);

    logic [7:0] w_q;

    always_comb begin
        is_ctl = 1'b1;
        ctl    = 2'b00;
        case (sym)
            CTL_SYM_00: ctl = 2'b00;
            CTL_SYM_01: ctl = 2'b01;
            CTL_SYM_10: ctl = 2'b10;
            CTL_SYM_11: ctl = 2'b11;
            default:    is_ctl = 1'b0;
        endcase
    end

    // Bit 9 flags DC-balance inversion, bit 8 selects XOR vs XNOR chaining.
    always_comb begin
        w_q  = sym[9] ? ~sym[7:0] : sym[7:0];
        d    = 8'h00;
        d[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = sym[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
// Aligns a raw deserialized TMDS word stream by bit slipping until a run of
// control symbols is seen, then decodes data/control symbols.
// Parameters:
//   LOCK_RUN  consecutive control symbols needed to declare lock
//   SLIP_WAIT cycles without a control symbol in SEARCH before a bit slip
//   LOSS_WAIT cycles without a control symbol in LOCKED before lock is dropped
// Ports:
//   clk_i    in  1   clock, rising edge
//   rst_ni   in  1   asynchronous active-low reset
//   sym_i    in  10  raw word, bit 0 earliest received
//   de_o     out 1   d_o holds a decoded data byte
//   d_o      out 8   decoded pixel byte
//   ctl_o    out 2   decoded control bits {c1,c0}
//   locked_o out 1   symbol alignment achieved
//   offset_o out 4   current bit-slip offset 0..9
// Latency: a word sampled at edge k (offset 0) is on the outputs after edge k+2.
// -----------------------------------------------------------------------------
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN  = 8,
    parameter int SLIP_WAIT = 1024,
    parameter int LOSS_WAIT = 2048
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [9:0] sym_i,
    output logic       de_o,
    output logic [7:0] d_o,
    output logic [1:0] ctl_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int RUN_W   = $clog2(LOCK_RUN) + 1;
    localparam int TMR_MAX = (SLIP_WAIT > LOSS_WAIT) ? SLIP_WAIT : LOSS_WAIT;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [RUN_W-1:0] RUN_LOCK  = RUN_W'(LOCK_RUN);
    localparam logic [TMR_W-1:0] SLIP_LAST = TMR_W'(SLIP_WAIT - 1);
    localparam logic [TMR_W-1:0] LOSS_LAST = TMR_W'(LOSS_WAIT - 1);

    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [9:0]       r_s1_p0;
    logic [9:0]       r_s2_p1;
    logic [3:0]       r_offset;
    logic [RUN_W-1:0] r_run;
    logic [TMR_W-1:0] r_tmr;
    tmds_state_e      r_state;
    logic             r_locked_p2;
    logic             r_de_p2;
    logic [7:0]       r_d_p2;
    logic [1:0]       r_ctl_p2;

    logic [19:0]      w_window;
    logic [9:0]       w_aligned;
    logic             w_is_ctl;
    logic [1:0]       w_ctl;
    logic [7:0]       w_d;
    logic [RUN_W-1:0] w_run_nxt;
    logic             w_lock_nxt;

    // ---- stage p1: two-word window, aligned symbol selected by offset ----
    assign w_window  = {r_s1_p0, r_s2_p1};
    assign w_aligned = w_window[{1'b0, r_offset} +: 10];

    tmds_sym_decode u_dec (
        .sym    (w_aligned),
        .is_ctl (w_is_ctl),
        .ctl    (w_ctl),
        .d      (w_d)
    );

    assign w_run_nxt = run_inc(r_run);

    // Lock status after this edge; the output stage uses it so that the
    // symbol that completes the lock run is already presented as locked,
    // and the symbol that loses lock is already forced to idle.
    always_comb begin
        if (r_state == ST_SEARCH) begin
            w_lock_nxt = w_is_ctl && (w_run_nxt >= RUN_LOCK);
        end else begin
            w_lock_nxt = w_is_ctl || (r_tmr < LOSS_LAST);
        end
    end

    // ---- stage p2: alignment FSM and registered outputs ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_p0     <= '0;
            r_s2_p1     <= '0;
            r_offset    <= '0;
            r_run       <= '0;
            r_tmr       <= '0;
            r_state     <= ST_SEARCH;
            r_locked_p2 <= 1'b0;
            r_de_p2     <= 1'b0;
            r_d_p2      <= '0;
            r_ctl_p2    <= '0;
        end else begin
            r_s1_p0 <= sym_i;
            r_s2_p1 <= r_s1_p0;

            if (r_state == ST_SEARCH) begin
                if (w_is_ctl) begin
                    // A control symbol beats a coinciding slip timeout.
                    r_tmr <= '0;
                    r_run <= w_run_nxt;
                    if (w_run_nxt >= RUN_LOCK) begin
                        r_state <= ST_LOCKED;
                    end
                end else begin
                    r_run <= '0;
                    if (r_tmr >= SLIP_LAST) begin
                        r_offset <= next_offset(r_offset);
                        r_tmr    <= '0;
                    end else begin
                        r_tmr <= tmr_inc(r_tmr);
                    end
                end
            end else begin
                if (w_is_ctl) begin
                    r_tmr <= '0;
                end else if (r_tmr >= LOSS_LAST) begin
                    // Offset is kept: the link most likely only glitched.
                    r_state <= ST_SEARCH;
                    r_tmr   <= '0;
                    r_run   <= '0;
                end else begin
                    r_tmr <= tmr_inc(r_tmr);
                end
            end

            r_locked_p2 <= w_lock_nxt;
            if (!w_lock_nxt) begin
                r_de_p2  <= 1'b0;
                r_d_p2   <= '0;
                r_ctl_p2 <= '0;
            end else if (w_is_ctl) begin
                r_de_p2  <= 1'b0;
                r_d_p2   <= '0;
                r_ctl_p2 <= w_ctl;
            end else begin
                r_de_p2 <= 1'b1;
                r_d_p2  <= w_d;
            end
        end
    end

    assign de_o     = r_de_p2;
    assign d_o      = r_d_p2;
    assign ctl_o    = r_ctl_p2;
    assign locked_o = r_locked_p2;
    assign offset_o = r_offset;

endmodule

// File: tb/tb_tmds_decoder.sv
module tb_tmds_decoder;

    localparam int LOCK_RUN  = 8;
    localparam int SLIP_WAIT = 1024;
    localparam int LOSS_WAIT = 2048;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] D10 = 10'b0111110000;  // decodes to 0x10
    localparam logic [9:0] DEF = 10'b1011110000;  // decodes to 0xEF

    logic       clk    = 1'b0;
    logic       rst_ni = 1'b0;
    logic [9:0] sym_i  = '0;
    logic       de_o;
    logic [7:0] d_o;
    logic [1:0] ctl_o;
    logic       locked_o;
    logic [3:0] offset_o;

    int n_cmp = 0;
    int n_bad = 0;

    tmds_decoder #(
        .LOCK_RUN  (LOCK_RUN),
        .SLIP_WAIT (SLIP_WAIT),
        .LOSS_WAIT (LOSS_WAIT)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .sym_i    (sym_i),
        .de_o     (de_o),
        .d_o      (d_o),
        .ctl_o    (ctl_o),
        .locked_o (locked_o),
        .offset_o (offset_o)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    function automatic logic [9:0] f_align(input logic [9:0] s1, input logic [9:0] s2, input int off);
        logic       bits [20];
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            bits[i]      = s2[i];
            bits[i + 10] = s1[i];
        end
        for (int j = 0; j < 10; j++) r[j] = bits[off + j];
        return r;
    endfunction

    function automatic int f_ctl_idx(input logic [9:0] s);
        if (s == C00) return 0;
        if (s == C01) return 1;
        if (s == C10) return 2;
        if (s == C11) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] f_dec(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] r;
        q    = s[9] ? ~s[7:0] : s[7:0];
        r    = '0;
        r[0] = q[0];
        for (int i = 1; i < 8; i++) r[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return r;
    endfunction

    logic [9:0] m_s1, m_s2;
    int         m_off, m_run, m_tmr;
    bit         m_lock;
    logic       e_de;
    logic [7:0] e_d;
    logic [1:0] e_ctl;

    logic [9:0] n_sym;
    int         n_idx, n_off, n_run, n_tmr;
    bit         n_lock;
    logic       n_de;
    logic [7:0] n_d;
    logic [1:0] n_ctl;

    always_comb begin
        n_sym  = f_align(m_s1, m_s2, m_off);
        n_idx  = f_ctl_idx(n_sym);
        n_off  = m_off;
        n_run  = m_run;
        n_tmr  = m_tmr;
        n_lock = m_lock;
        if (!m_lock) begin
            if (n_idx >= 0) begin
                n_tmr = 0;
                n_run = m_run + 1;
                if (n_run >= LOCK_RUN) n_lock = 1'b1;
            end else begin
                n_run = 0;
                if (m_tmr == SLIP_WAIT - 1) begin
                    n_off = (m_off + 1) % 10;
                    n_tmr = 0;
                end else begin
                    n_tmr = m_tmr + 1;
                end
            end
        end else begin
            if (n_idx >= 0) begin
                n_tmr = 0;
            end else if (m_tmr == LOSS_WAIT - 1) begin
                n_lock = 1'b0;
                n_tmr  = 0;
                n_run  = 0;
            end else begin
                n_tmr = m_tmr + 1;
            end
        end
        n_de  = 1'b0;
        n_d   = 8'h00;
        n_ctl = 2'b00;
        if (n_lock) begin
            if (n_idx >= 0) begin
                n_ctl = 2'(n_idx);
            end else begin
                n_de  = 1'b1;
                n_d   = f_dec(n_sym);
                n_ctl = e_ctl;
            end
        end
    end

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_s1   <= '0;
            m_s2   <= '0;
            m_off  <= 0;
            m_run  <= 0;
            m_tmr  <= 0;
            m_lock <= 1'b0;
            e_de   <= 1'b0;
            e_d    <= '0;
            e_ctl  <= '0;
        end else begin
            m_s1   <= sym_i;
            m_s2   <= m_s1;
            m_off  <= n_off;
            m_run  <= n_run;
            m_tmr  <= n_tmr;
            m_lock <= n_lock;
            e_de   <= n_de;
            e_d    <= n_d;
            e_ctl  <= n_ctl;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        n_cmp++;
        if (de_o !== e_de || d_o !== e_d || ctl_o !== e_ctl ||
            locked_o !== m_lock || offset_o !== 4'(m_off)) begin
            n_bad++;
            $display("FAIL model t=%0t got de=%b d=%h ctl=%b lk=%b off=%0d expected de=%b d=%h ctl=%b lk=%b off=%0d",
                     $time, de_o, d_o, ctl_o, locked_o, offset_o, e_de, e_d, e_ctl, m_lock, m_off);
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [9:0] v);
        sym_i = v;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] dl_prev = '0;

    // Emits the next raw word of a stream that is late by d bits.
    task automatic step_dly(input logic [9:0] v, input int d);
        logic [19:0] t;
        t = {v, dl_prev} >> (10 - d);
        dl_prev = v;
        step((d == 0) ? v : t[9:0]);
    endtask

    // Data symbol whose top three and bottom three bits are each equal:
    // any 10-bit window over a stream of these holds a run of three equal
    // bits, which no control symbol has, so misalignment never fakes control.
    function automatic logic [9:0] gen_data();
        logic       a, b;
        logic [3:0] m;
        a = 1'($urandom);
        b = 1'($urandom);
        m = 4'($urandom);
        return {{3{a}}, m, {3{b}}};
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (3) begin
            sym_i = 10'($urandom);
            @(posedge clk);
            #1;
        end
        sym_i   = '0;
        dl_prev = '0;
        rst_ni  = 1'b1;
    endtask

    task automatic chk_out(input string nm, input logic lk, input logic de, input logic [7:0] d, input logic [1:0] c);
        chk({nm, "_locked"}, 16'(locked_o), 16'(lk));
        chk({nm, "_de"},     16'(de_o),     16'(de));
        chk({nm, "_d"},      16'(d_o),      16'(d));
        chk({nm, "_ctl"},    16'(ctl_o),    16'(c));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int  prev_off;
        bit  saw_wrap;
        int  dly;
        int  cnt;

        // Reset held with random input
        rst_ni = 1'b0;
        repeat (4) begin
            sym_i = 10'($urandom);
            @(posedge clk);
            #1;
            chk_out("reset", 1'b0, 1'b0, 8'h00, 2'b00);
            chk("reset_offset", 16'(offset_o), 16'd0);
        end
        sym_i  = '0;
        rst_ni = 1'b1;

        // Aligned lock, data decode, then all four control symbols
        repeat (8) step(C00);
        step(D10);
        chk_out("seven_ctl", 1'b0, 1'b0, 8'h00, 2'b00);
        step(DEF);
        chk_out("lock", 1'b1, 1'b0, 8'h00, 2'b00);
        step(C01);
        chk_out("data_10", 1'b1, 1'b1, 8'h10, 2'b00);
        step(C10);
        chk_out("data_ef", 1'b1, 1'b1, 8'hEF, 2'b00);
        step(C11);
        chk_out("ctl_01", 1'b1, 1'b0, 8'h00, 2'b01);
        step(C00);
        chk_out("ctl_10", 1'b1, 1'b0, 8'h00, 2'b10);
        step(C00);
        chk_out("ctl_11", 1'b1, 1'b0, 8'h00, 2'b11);
        step(C00);
        chk_out("ctl_00", 1'b1, 1'b0, 8'h00, 2'b00);

        // Loss of lock after LOSS_WAIT data symbols
        repeat (LOSS_WAIT + 1) step(gen_data());
        chk("loss_still_locked", 16'(locked_o), 16'd1);
        step(gen_data());
        chk("loss_locked", 16'(locked_o), 16'd0);
        chk("loss_de", 16'(de_o), 16'd0);
        chk("loss_offset", 16'(offset_o), 16'd0);

        // Slip acquisition on a stream 3 bits late
        do_reset();
        prev_off = 0;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 800; i++) begin
                step_dly((i < 640) ? gen_data() : C00, 3);
                if (int'(offset_o) != prev_off) begin
                    chk("slip_step", 16'(offset_o), 16'(prev_off + 1));
                    prev_off = int'(offset_o);
                end
            end
        end
        chk("slip_offset", 16'(offset_o), 16'd3);
        chk("slip_locked", 16'(locked_o), 16'd1);
        step_dly(D10, 3);
        step_dly(C00, 3);
        step_dly(C00, 3);
        chk("slip_data_de", 16'(de_o), 16'd1);
        chk("slip_data_d", 16'(d_o), 16'h10);
        step_dly(C00, 3);

        // Reset while locked clears at once; lock then comes back at offset 0
        #1;
        rst_ni = 1'b0;
        #1;
        chk_out("midreset", 1'b0, 1'b0, 8'h00, 2'b00);
        chk("midreset_offset", 16'(offset_o), 16'd0);
        @(posedge clk);
        #1;
        sym_i  = '0;
        rst_ni = 1'b1;
        repeat (10) step(C00);
        chk("relock_locked", 16'(locked_o), 16'd1);
        chk("relock_offset", 16'(offset_o), 16'd0);

        // Slip wrap 9 -> 0 on a data-only stream
        do_reset();
        prev_off = 0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 10 * SLIP_WAIT + 40; i++) begin
            step(gen_data());
            if (prev_off == 9 && int'(offset_o) != 9) begin
                saw_wrap = 1'b1;
                chk("wrap_value", 16'(offset_o), 16'd0);
            end
            prev_off = int'(offset_o);
        end
        chk("wrap_seen", 16'(saw_wrap), 16'd1);
        chk("wrap_offset", 16'(offset_o), 16'd0);

        // Randomized bursts at a random delay, checked by the model only
        do_reset();
        dly = $urandom_range(0, 9);
        cnt = 0;
        while (cnt < 6000) begin
            int nd;
            int nc;
            nd = $urandom_range(1, 1300);
            nc = $urandom_range(1, 20);
            for (int i = 0; i < nd; i++) begin
                step_dly(($urandom_range(0, 3) == 0) ? 10'($urandom) : gen_data(), dly);
            end
            for (int i = 0; i < nc; i++) begin
                case ($urandom_range(0, 3))
                    0:       step_dly(C00, dly);
                    1:       step_dly(C01, dly);
                    2:       step_dly(C10, dly);
                    default: step_dly(C11, dly);
                endcase
            end
            cnt += nd + nc;
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
